// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and encodings for the MEM-stage data-bus controller.
// Load/store type codes follow the decoder's encoding; size codes follow the bus.
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        LT_NONE = 3'd0,
        LT_LB   = 3'd1,
        LT_LBU  = 3'd2,
        LT_LH   = 3'd3,
        LT_LHU  = 3'd4,
        LT_LW   = 3'd5
    } load_type_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SB   = 2'd1,
        ST_SH   = 2'd2,
        ST_SW   = 2'd3
    } store_type_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_DONE      = 3'd3,
        S_CANCEL    = 3'd4
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    function automatic logic [1:0] load_size(load_type_e lt);
        case (lt)
            LT_LB, LT_LBU: return SZ_BYTE;
            LT_LH, LT_LHU: return SZ_HALF;
            default:       return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// SRAM-like data bus between the MEM stage controller (master) and the
// data cache / bus bridge (slave).
interface mem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic [31:0]           data_wdata;
    logic [3:0]            data_wstrb;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [31:0]           data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half of a raw read word and sign/zero-extends it.
module mem_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  load_type_e  load_type,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (load_type)
            LT_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  result = {24'd0, byte_sel};
            LT_LH:   result = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: issues one bus transaction per instruction,
// stalls the pipeline until it completes, and returns extended load data.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  IDLE      | no access in flight; a valid load/store starts one
//  REQ       | data_req held with captured fields until data_addr_ok
//  WAIT_DATA | accepted, waiting for data_data_ok
//  DONE      | result available, held until the stage advances or flushes
//  CANCEL    | flushed after acceptance; swallow the outstanding data_ok
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Valid,
    input  logic [31:0] MEM_ALUOut,
    input  logic [31:0] MEM_OutB,
    input  logic [2:0]  MEM_LoadType,
    input  logic [1:0]  MEM_StoreType,
    input  logic        MEM_ExceptValid,
    input  logic        MEM_Flush,
    input  logic        MEM_Adv,
    mem_access_ctrl_if.master bus,
    output logic        MEM_Stall,
    output logic [31:0] MEM_LoadData,
    output logic        MEM_LoadValid
);

    state_e state, state_nxt;

    logic                  start;
    logic                  is_store;
    logic                  flush_pend, pend_nxt;
    logic                  killed;
    logic                  latch_load;

    logic [1:0]            enc_size;
    logic [31:0]           enc_wdata;
    logic [3:0]            enc_wstrb;

    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [1:0]            cap_size;
    logic                  cap_wr;
    logic [31:0]           cap_wdata;
    logic [3:0]            cap_wstrb;
    load_type_e            cap_lt;

    logic [31:0]           aligned;

    assign is_store = (store_type_e'(MEM_StoreType) != ST_NONE);
    assign start    = MEM_Valid & ((load_type_e'(MEM_LoadType) != LT_NONE) | is_store)
                      & ~MEM_ExceptValid & ~MEM_Flush;
    // A flush seen while the request is still unaccepted must outlive its pulse.
    assign killed   = flush_pend | MEM_Flush;

    always_comb begin
        enc_size  = load_size(load_type_e'(MEM_LoadType));
        enc_wdata = MEM_OutB;
        enc_wstrb = 4'h0;
        case (store_type_e'(MEM_StoreType))
            ST_SB: begin
                enc_size  = SZ_BYTE;
                enc_wdata = {4{MEM_OutB[7:0]}};
                enc_wstrb = 4'b0001 << MEM_ALUOut[1:0];
            end
            ST_SH: begin
                enc_size  = SZ_HALF;
                enc_wdata = {2{MEM_OutB[15:0]}};
                enc_wstrb = 4'b0011 << {MEM_ALUOut[1], 1'b0};
            end
            ST_SW: begin
                enc_size  = SZ_WORD;
                enc_wdata = MEM_OutB;
                enc_wstrb = 4'hF;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        pend_nxt   = 1'b0;
        latch_load = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_REQ;
            S_REQ: begin
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        if (killed) begin
                            state_nxt = S_IDLE;
                        end else begin
                            state_nxt  = S_DONE;
                            latch_load = 1'b1;
                        end
                    end else begin
                        state_nxt = killed ? S_CANCEL : S_WAIT_DATA;
                    end
                end else begin
                    pend_nxt = killed;
                end
            end
            S_WAIT_DATA: begin
                if (bus.data_data_ok) begin
                    if (MEM_Flush) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt  = S_DONE;
                        latch_load = 1'b1;
                    end
                end else if (MEM_Flush) begin
                    state_nxt = S_CANCEL;
                end
            end
            S_DONE:   if (MEM_Flush || MEM_Adv) state_nxt = S_IDLE;
            S_CANCEL: if (bus.data_data_ok) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            flush_pend   <= 1'b0;
            cap_addr     <= '0;
            cap_size     <= '0;
            cap_wr       <= 1'b0;
            cap_wdata    <= '0;
            cap_wstrb    <= '0;
            cap_lt       <= LT_NONE;
            MEM_LoadData <= '0;
        end else begin
            state      <= state_nxt;
            flush_pend <= pend_nxt;
            if (state == S_IDLE && start) begin
                cap_addr  <= MEM_ALUOut[ADDR_WIDTH-1:0];
                cap_size  <= enc_size;
                cap_wr    <= is_store;
                cap_wdata <= enc_wdata;
                cap_wstrb <= enc_wstrb;
                cap_lt    <= is_store ? LT_NONE : load_type_e'(MEM_LoadType);
            end
            if (latch_load && cap_lt != LT_NONE) MEM_LoadData <= aligned;
        end
    end

    mem_load_align u_align (
        .rdata     (bus.data_rdata),
        .addr_lo   (cap_addr[1:0]),
        .load_type (cap_lt),
        .result    (aligned)
    );

    assign bus.data_req   = (state == S_REQ);
    assign bus.data_wr    = cap_wr;
    assign bus.data_size  = cap_size;
    assign bus.data_addr  = cap_addr;
    assign bus.data_wdata = cap_wdata;
    assign bus.data_wstrb = cap_wstrb;

    // Gated by reset so the stall is low while reset is held even if start is up.
    assign MEM_Stall = rst & (((state == S_IDLE) & start) | (state == S_REQ)
                              | (state == S_WAIT_DATA) | (state == S_CANCEL));
    assign MEM_LoadValid = (state == S_DONE) & (cap_lt != LT_NONE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; the bench plays the bus bridge.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        MEM_Valid;
    logic [31:0] MEM_ALUOut;
    logic [31:0] MEM_OutB;
    logic [2:0]  MEM_LoadType;
    logic [1:0]  MEM_StoreType;
    logic        MEM_ExceptValid;
    logic        MEM_Flush;
    logic        MEM_Adv;
    logic        MEM_Stall;
    logic [31:0] MEM_LoadData;
    logic        MEM_LoadValid;

    int passed = 0;
    int total  = 0;

    mem_access_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    mem_access_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .MEM_Valid       (MEM_Valid),
        .MEM_ALUOut      (MEM_ALUOut),
        .MEM_OutB        (MEM_OutB),
        .MEM_LoadType    (MEM_LoadType),
        .MEM_StoreType   (MEM_StoreType),
        .MEM_ExceptValid (MEM_ExceptValid),
        .MEM_Flush       (MEM_Flush),
        .MEM_Adv         (MEM_Adv),
        .bus             (bus),
        .MEM_Stall       (MEM_Stall),
        .MEM_LoadData    (MEM_LoadData),
        .MEM_LoadValid   (MEM_LoadValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [31:0] a, input logic [31:0] d,
                             input load_type_e lt, input store_type_e st);
        MEM_Valid       = v;
        MEM_ALUOut      = a;
        MEM_OutB        = d;
        MEM_LoadType    = lt;
        MEM_StoreType   = st;
        MEM_ExceptValid = 1'b0;
        MEM_Flush       = 1'b0;
    endtask

    task automatic retire();
        MEM_Adv = 1'b1;
        tick();
        MEM_Adv = 1'b0;
        set_instr(1'b0, 32'h0, 32'h0, LT_NONE, ST_NONE);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_instr(1'b1, 32'h0000_0044, 32'h0, LT_LW, ST_NONE);
        MEM_Adv = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;
        tick(); tick();
        total++; if (MEM_Stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", MEM_Stall); else passed++;
        total++; if (bus.data_req !== 1'b0) $display("FAIL reset_req got %0b want 0", bus.data_req); else passed++;
        total++; if (bus.data_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", bus.data_addr); else passed++;
        total++; if (MEM_LoadData !== 32'h0) $display("FAIL reset_ldata got %h want 0", MEM_LoadData); else passed++;
        total++; if (MEM_LoadValid !== 1'b0) $display("FAIL reset_lvalid got %0b want 0", MEM_LoadValid); else passed++;
        set_instr(1'b0, 32'h0, 32'h0, LT_NONE, ST_NONE);
        #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_sw();
        set_instr(1'b1, 32'h8000_0010, 32'h1234_5678, LT_NONE, ST_SW);
        #1;
        total++; if (MEM_Stall !== 1'b1) $display("FAIL sw_stall_c0 got %0b want 1", MEM_Stall); else passed++;
        total++; if (bus.data_req !== 1'b0) $display("FAIL sw_req_c0 got %0b want 0", bus.data_req); else passed++;
        tick();
        total++; if (bus.data_req !== 1'b1) $display("FAIL sw_req got %0b want 1", bus.data_req); else passed++;
        total++; if (bus.data_wr !== 1'b1) $display("FAIL sw_wr got %0b want 1", bus.data_wr); else passed++;
        total++; if (bus.data_size !== 2'd2) $display("FAIL sw_size got %0d want 2", bus.data_size); else passed++;
        total++; if (bus.data_wstrb !== 4'hF) $display("FAIL sw_wstrb got %h want f", bus.data_wstrb); else passed++;
        total++; if (bus.data_wdata !== 32'h1234_5678) $display("FAIL sw_wdata got %h want 12345678", bus.data_wdata); else passed++;
        total++; if (bus.data_addr !== 32'h8000_0010) $display("FAIL sw_addr got %h want 80000010", bus.data_addr); else passed++;
        total++; if (MEM_Stall !== 1'b1) $display("FAIL sw_stall_c1 got %0b want 1", MEM_Stall); else passed++;
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        #1;
        total++; if (MEM_Stall !== 1'b0) $display("FAIL sw_stall_done got %0b want 0", MEM_Stall); else passed++;
        total++; if (bus.data_req !== 1'b0) $display("FAIL sw_req_done got %0b want 0", bus.data_req); else passed++;
        total++; if (MEM_LoadValid !== 1'b0) $display("FAIL sw_lvalid got %0b want 0", MEM_LoadValid); else passed++;
        retire();
        total++; if (MEM_Stall !== 1'b0) $display("FAIL sw_stall_idle got %0b want 0", MEM_Stall); else passed++;
    endtask

    task automatic test_load_extend();
        load_type_e  lt_v [8];
        logic [31:0] ad_v [8];
        logic [31:0] rd_v [8];
        logic [31:0] ex_v [8];
        lt_v[0] = LT_LB;  ad_v[0] = 32'h0000_0013; rd_v[0] = 32'h80FF_0000; ex_v[0] = 32'hFFFF_FF80;
        lt_v[1] = LT_LBU; ad_v[1] = 32'h0000_0013; rd_v[1] = 32'h80FF_0000; ex_v[1] = 32'h0000_0080;
        lt_v[2] = LT_LB;  ad_v[2] = 32'h0000_0012; rd_v[2] = 32'h80FF_0000; ex_v[2] = 32'hFFFF_FFFF;
        lt_v[3] = LT_LB;  ad_v[3] = 32'h0000_0011; rd_v[3] = 32'h80FF_0000; ex_v[3] = 32'h0000_0000;
        lt_v[4] = LT_LH;  ad_v[4] = 32'h0000_0012; rd_v[4] = 32'h80FF_0000; ex_v[4] = 32'hFFFF_80FF;
        lt_v[5] = LT_LHU; ad_v[5] = 32'h0000_0012; rd_v[5] = 32'h80FF_0000; ex_v[5] = 32'h0000_80FF;
        lt_v[6] = LT_LH;  ad_v[6] = 32'h0000_0010; rd_v[6] = 32'h80FF_7FFE; ex_v[6] = 32'h0000_7FFE;
        lt_v[7] = LT_LW;  ad_v[7] = 32'h0000_0010; rd_v[7] = 32'h80FF_0000; ex_v[7] = 32'h80FF_0000;
        for (int i = 0; i < 8; i++) begin
            set_instr(1'b1, ad_v[i], 32'h0, lt_v[i], ST_NONE);
            tick();
            bus.data_rdata   = rd_v[i];
            bus.data_addr_ok = 1'b1;
            bus.data_data_ok = 1'b1;
            tick();
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            bus.data_rdata   = 32'h0;
            #1;
            total++; if (MEM_LoadValid !== 1'b1) $display("FAIL load%0d_lvalid got %0b want 1", i, MEM_LoadValid); else passed++;
            total++; if (MEM_LoadData !== ex_v[i]) $display("FAIL load%0d_data got %h want %h", i, MEM_LoadData, ex_v[i]); else passed++;
            retire();
        end
    endtask

    task automatic test_sub_word_store();
        logic [31:0] ad_v [3];
        logic [31:0] d_v  [3];
        store_type_e st_v [3];
        logic [31:0] wd_v [3];
        logic [3:0]  ws_v [3];
        logic [1:0]  sz_v [3];
        st_v[0] = ST_SH; ad_v[0] = 32'h0000_0102; d_v[0] = 32'h0000_ABCD; wd_v[0] = 32'hABCD_ABCD; ws_v[0] = 4'b1100; sz_v[0] = 2'd1;
        st_v[1] = ST_SH; ad_v[1] = 32'h0000_0100; d_v[1] = 32'h1111_2345; wd_v[1] = 32'h2345_2345; ws_v[1] = 4'b0011; sz_v[1] = 2'd1;
        st_v[2] = ST_SB; ad_v[2] = 32'h0000_0101; d_v[2] = 32'h0000_775A; wd_v[2] = 32'h5A5A_5A5A; ws_v[2] = 4'b0010; sz_v[2] = 2'd0;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, ad_v[i], d_v[i], LT_NONE, st_v[i]);
            tick();
            total++; if (bus.data_wdata !== wd_v[i]) $display("FAIL st%0d_wdata got %h want %h", i, bus.data_wdata, wd_v[i]); else passed++;
            total++; if (bus.data_wstrb !== ws_v[i]) $display("FAIL st%0d_wstrb got %b want %b", i, bus.data_wstrb, ws_v[i]); else passed++;
            total++; if (bus.data_size !== sz_v[i]) $display("FAIL st%0d_size got %0d want %0d", i, bus.data_size, sz_v[i]); else passed++;
            bus.data_addr_ok = 1'b1;
            bus.data_data_ok = 1'b1;
            tick();
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            retire();
        end
    endtask

    task automatic test_lw_delayed_and_hold();
        set_instr(1'b1, 32'h0000_0444, 32'hDEAD_BEEF, LT_LW, ST_NONE);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h0000_0444)
                $display("FAIL lw_hold%0d got req %0b addr %h want 1 00000444", i, bus.data_req, bus.data_addr); else passed++;
            total++; if (MEM_Stall !== 1'b1) $display("FAIL lw_stall_req%0d got %0b want 1", i, MEM_Stall); else passed++;
            tick();
        end
        bus.data_addr_ok = 1'b1;
        #1;
        total++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h0000_0444)
            $display("FAIL lw_hold3 got req %0b addr %h want 1 00000444", bus.data_req, bus.data_addr); else passed++;
        total++; if (bus.data_wr !== 1'b0 || bus.data_wstrb !== 4'h0 || bus.data_size !== 2'd2)
            $display("FAIL lw_fields got wr %0b wstrb %h size %0d want 0 0 2", bus.data_wr, bus.data_wstrb, bus.data_size); else passed++;
        tick();
        bus.data_addr_ok = 1'b0;
        #1;
        total++; if (bus.data_req !== 1'b0 || MEM_Stall !== 1'b1)
            $display("FAIL lw_wait got req %0b stall %0b want 0 1", bus.data_req, MEM_Stall); else passed++;
        tick();
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hCAFE_F00D;
        #1;
        total++; if (MEM_Stall !== 1'b1 || MEM_LoadValid !== 1'b0)
            $display("FAIL lw_wait2 got stall %0b lvalid %0b want 1 0", MEM_Stall, MEM_LoadValid); else passed++;
        tick();
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;
        #1;
        total++; if (MEM_Stall !== 1'b0 || MEM_LoadValid !== 1'b1)
            $display("FAIL lw_done got stall %0b lvalid %0b want 0 1", MEM_Stall, MEM_LoadValid); else passed++;
        total++; if (MEM_LoadData !== 32'hCAFE_F00D) $display("FAIL lw_data got %h want cafef00d", MEM_LoadData); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.data_rdata = $urandom;
            #1;
            total++; if (MEM_LoadData !== 32'hCAFE_F00D || MEM_LoadValid !== 1'b1)
                $display("FAIL done_hold%0d got data %h lvalid %0b want cafef00d 1", i, MEM_LoadData, MEM_LoadValid); else passed++;
            total++; if (bus.data_req !== 1'b0 || MEM_Stall !== 1'b0)
                $display("FAIL done_noreq%0d got req %0b stall %0b want 0 0", i, bus.data_req, MEM_Stall); else passed++;
        end
        bus.data_rdata = 32'h0;
        retire();
    endtask

    task automatic test_flush_wait();
        set_instr(1'b1, 32'h0000_0888, 32'h0, LT_LW, ST_NONE);
        tick();
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        MEM_Flush = 1'b1;
        #1;
        total++; if (MEM_Stall !== 1'b1) $display("FAIL fw_stall_wait got %0b want 1", MEM_Stall); else passed++;
        tick();
        MEM_Flush = 1'b0;
        MEM_Valid = 1'b0;
        #1;
        total++; if (MEM_Stall !== 1'b1 || bus.data_req !== 1'b0 || MEM_LoadValid !== 1'b0)
            $display("FAIL fw_cancel got stall %0b req %0b lvalid %0b want 1 0 0", MEM_Stall, bus.data_req, MEM_LoadValid); else passed++;
        tick();
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h1111_1111;
        #1;
        total++; if (MEM_Stall !== 1'b1 || MEM_LoadValid !== 1'b0)
            $display("FAIL fw_cancel2 got stall %0b lvalid %0b want 1 0", MEM_Stall, MEM_LoadValid); else passed++;
        tick();
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;
        #1;
        total++; if (MEM_Stall !== 1'b0 || MEM_LoadValid !== 1'b0)
            $display("FAIL fw_idle got stall %0b lvalid %0b want 0 0", MEM_Stall, MEM_LoadValid); else passed++;
        total++; if (MEM_LoadData !== 32'hCAFE_F00D) $display("FAIL fw_discard got %h want cafef00d", MEM_LoadData); else passed++;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (bus.data_req !== 1'b0) $display("FAIL fw_noreissue%0d got %0b want 0", i, bus.data_req); else passed++;
        end
    endtask

    task automatic test_flush_req();
        set_instr(1'b1, 32'h0000_0900, 32'h0, LT_LW, ST_NONE);
        tick();
        MEM_Flush = 1'b1;
        #1;
        total++; if (bus.data_req !== 1'b1) $display("FAIL fr_req got %0b want 1", bus.data_req); else passed++;
        tick();
        MEM_Flush = 1'b0;
        MEM_Valid = 1'b0;
        #1;
        total++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h0000_0900)
            $display("FAIL fr_held got req %0b addr %h want 1 00000900", bus.data_req, bus.data_addr); else passed++;
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        #1;
        total++; if (bus.data_req !== 1'b0 || MEM_Stall !== 1'b1)
            $display("FAIL fr_cancel got req %0b stall %0b want 0 1", bus.data_req, MEM_Stall); else passed++;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h2222_2222;
        tick();
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;
        #1;
        total++; if (MEM_Stall !== 1'b0 || MEM_LoadValid !== 1'b0 || MEM_LoadData !== 32'hCAFE_F00D)
            $display("FAIL fr_idle got stall %0b lvalid %0b data %h want 0 0 cafef00d", MEM_Stall, MEM_LoadValid, MEM_LoadData); else passed++;
    endtask

    task automatic test_except();
        set_instr(1'b1, 32'h0000_0501, 32'h0, LT_LW, ST_NONE);
        MEM_ExceptValid = 1'b1;
        #1;
        total++; if (MEM_Stall !== 1'b0 || bus.data_req !== 1'b0)
            $display("FAIL exc_c0 got stall %0b req %0b want 0 0", MEM_Stall, bus.data_req); else passed++;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (MEM_Stall !== 1'b0 || bus.data_req !== 1'b0)
                $display("FAIL exc_c%0d got stall %0b req %0b want 0 0", i + 1, MEM_Stall, bus.data_req); else passed++;
        end
        set_instr(1'b0, 32'h0, 32'h0, LT_NONE, ST_NONE);
        tick();
    endtask

    task automatic test_async_reset();
        set_instr(1'b1, 32'h0000_0040, 32'h0, LT_LW, ST_NONE);
        tick();
        total++; if (bus.data_req !== 1'b1) $display("FAIL ar_req got %0b want 1", bus.data_req); else passed++;
        #2;
        rst = 1'b0;
        #1;
        total++; if (bus.data_req !== 1'b0 || MEM_Stall !== 1'b0)
            $display("FAIL ar_now got req %0b stall %0b want 0 0", bus.data_req, MEM_Stall); else passed++;
        total++; if (MEM_LoadData !== 32'h0 || bus.data_addr !== 32'h0)
            $display("FAIL ar_regs got data %h addr %h want 0 0", MEM_LoadData, bus.data_addr); else passed++;
        set_instr(1'b0, 32'h0, 32'h0, LT_NONE, ST_NONE);
        tick();
        rst = 1'b1;
        tick();
        total++; if (bus.data_req !== 1'b0 || MEM_Stall !== 1'b0)
            $display("FAIL ar_after got req %0b stall %0b want 0 0", bus.data_req, MEM_Stall); else passed++;
    endtask

    initial begin
        test_reset();
        test_sw();
        test_load_extend();
        test_sub_word_store();
        test_lw_delayed_and_hold();
        test_flush_wait();
        test_flush_req();
        test_except();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage consumer of the EXE/MEM pipeline register outputs.
- Turns a registered load/store (address, store data, load/store type) into an SRAM-like data-bus transaction.
- Generates the MEM stall, and returns aligned, sign/zero-extended load data to WB.
- Sits between the EXE/MEM register and the data cache / bus bridge.

Parameters:
ADDR_WIDTH, 32, data-bus address width (low 2 bits used for byte lanes)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
MEM_Valid  in  1  MEM stage holds a real instruction
MEM_ALUOut  in  32  effective address
MEM_OutB  in  32  raw store data (rt)
MEM_LoadType  in  3  LoadType (LT_NONE/LB/LBU/LH/LHU/LW)
MEM_StoreType  in  2  StoreType (ST_NONE/SB/SH/SW)
MEM_ExceptValid  in  1  instruction carries any exception (incl. misalign); suppresses access
MEM_Flush  in  1  pipeline flush of MEM stage
MEM_Adv  in  1  MEM stage advances to WB this cycle
data_req  out  1  bus request
data_wr  out  1  1 = store
data_size  out  2  0 byte, 1 half, 2 word
data_addr  out  ADDR_WIDTH  request address
data_wdata  out  32  lane-replicated store data
data_wstrb  out  4  byte enables (0 for loads)
data_addr_ok  in  1  request accepted
data_data_ok  in  1  read data / write ack returned
data_rdata  in  32  raw read word
MEM_Stall  out  1  hold IF..MEM
MEM_LoadData  out  32  extended load result
MEM_LoadValid  out  1  MEM_LoadData valid for current instruction

Behaviour:
- start = MEM_Valid & (LoadType!=LT_NONE | StoreType!=ST_NONE) & !MEM_ExceptValid & !MEM_Flush.
- While rst low: state=IDLE, all outputs 0, captured request registers 0.
- States: IDLE, REQ, WAIT_DATA, DONE, CANCEL.
- IDLE:
  - start -> REQ.
  - Capture addr, size, wr, wdata, wstrb, load type into registers.
  - MEM_Stall=1 combinationally in that same cycle.
- REQ:
  - data_req=1; all request fields come from the capture registers and stay stable until data_addr_ok.
  - addr_ok & data_ok in the same cycle -> DONE, latch rdata.
  - addr_ok only -> WAIT_DATA.
  - MEM_Flush with no addr_ok: req stays held (no retraction). On acceptance go to CANCEL, or to IDLE if data_ok arrives in the same cycle.
- WAIT_DATA:
  - data_ok -> DONE; latch extended rdata (loads only) into MEM_LoadData.
  - MEM_Flush -> CANCEL.
  - flush & data_ok in the same cycle -> IDLE, data discarded.
- DONE:
  - MEM_Stall=0, MEM_LoadValid=1 for loads.
  - Result held until MEM_Adv=1 -> IDLE; the instruction is never re-issued while held.
  - MEM_Flush -> IDLE.
- CANCEL: MEM_Stall=1; wait for data_ok, discard it, -> IDLE.
- MEM_Stall = (IDLE & start) | REQ | WAIT_DATA | CANCEL.
- Latency: minimum 2 cycles from start to DONE (IDLE->REQ->DONE with same-cycle addr_ok/data_ok).
- Store encoding:
  - SB: wdata={4{OutB[7:0]}}, wstrb=4'b0001<<addr[1:0], size 0.
  - SH: wdata={2{OutB[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}, size 1.
  - SW: wdata=OutB, wstrb=4'hF, size 2.
- Load encoding: wstrb=0, size as above, data_addr=ALUOut unmodified.
- Load extension:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - Sign- or zero-extend to 32 bits; LW passes through.
- Misalignment is never checked here; it arrives via MEM_ExceptValid.
- Async reset assertion mid-transaction returns to IDLE immediately. Bus-side cleanup is the bridge's responsibility (it shares the reset).

Decomposition:
- LoadType/StoreType enums and the state enum go in CPU_Defines.svh.
- Size encodings (SZ_BYTE/HALF/WORD) go in CommonDefines.svh.
- One combinational sub-module, mem_load_align: rdata, addr[1:0], LoadType -> extended 32-bit result.

Test Plan:
- SW addr 0x8000_0010 data 0x1234_5678, addr_ok+data_ok on first REQ cycle -> wstrb F, wdata 0x12345678, stall high exactly 2 cycles.
- LB addr 0x...13, rdata 0x80FF_0000 -> MEM_LoadData 0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr 0x...2, OutB 0xABCD -> wdata 0xABCDABCD, wstrb 4'b1100, size 1.
- LW with addr_ok delayed 3 cycles, data_ok 2 cycles later -> data_req held with stable addr for 4 cycles, stall through DONE entry, LoadValid=1.
- Flush in WAIT_DATA, data_ok 2 cycles later -> CANCEL, stall held, LoadValid stays 0, returns to IDLE with no second request.
- MEM_Adv=0 for 3 cycles in DONE -> LoadData stable, no new data_req; MEM_ExceptValid=1 with LW -> no data_req, stall 0.
